demux1x2_8bits: RTL and testbench

- Byte un-striper for the PHY receive path; the inverse of the 2-lane 8-bit interleaving mux.
- Takes one serial 8-bit stream qualified by a valid flag and splits alternate bytes onto two 8-bit lanes.
- Lane order matches the mux: the first byte after reset belongs to lane 1, the second to lane 0.
- Re-pairs bytes so that both lanes are presented together, and flushes a stranded half-pair after a timeout.

---
 rtl/demux1x2_8bits.sv | 97 +++++++++
 tb/tb_demux1x2_8bits.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux1x2_8bits.sv
// rtl/demux1x2_8bits.sv - 1:2 byte un-striper, first byte after reset/flush to lane 1.
// Optional completed-pair counter enabled by DEMUX_PAIR_CNT_EN.
module demux1x2_8bits #(
  parameter int unsigned TIMEOUT = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       data_in,
  input  logic             valid_in,
  output logic [7:0]       data_out0,
  output logic [7:0]       data_out1,
  output logic             valid_out0,
  output logic             valid_out1
`ifdef DEMUX_PAIR_CNT_EN
  ,
  output logic [CNT_W-1:0] pair_count
`endif
);

  localparam int unsigned IW        = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned LAST_IDLE = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic {IDLE, HALF} state_e;

  state_e          state_q;
  logic [7:0]      hold_q;
  logic [7:0]      data0_q;
  logic [7:0]      data1_q;
  logic            valid0_q;
  logic            valid1_q;
  logic [IW-1:0]   idle_q;
  logic            flush;
  logic            pair_done;

  // An arriving byte completes the pair even on the cycle the timeout expires.
  assign flush     = (TIMEOUT > 0) && (state_q == HALF) && !valid_in &&
                     (idle_q == IW'(LAST_IDLE));
  assign pair_done = (state_q == HALF) && valid_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      data0_q  <= '0;
      data1_q  <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      idle_q   <= '0;
    end else begin
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      if (state_q == IDLE) begin
        if (valid_in) begin
          hold_q  <= data_in;
          idle_q  <= '0;
          state_q <= HALF;
        end
      end else begin
        if (pair_done) begin
          data1_q  <= hold_q;
          data0_q  <= data_in;
          valid0_q <= 1'b1;
          valid1_q <= 1'b1;
          state_q  <= IDLE;
        end else if (flush) begin
          data1_q  <= hold_q;
          valid1_q <= 1'b1;
          state_q  <= IDLE;
        end else if ((TIMEOUT > 0) && (idle_q != '1)) begin
          idle_q <= idle_q + 1'b1;
        end
      end
    end
  end

  assign data_out0  = data0_q;
  assign data_out1  = data1_q;
  assign valid_out0 = valid0_q;
  assign valid_out1 = valid1_q;

`ifdef DEMUX_PAIR_CNT_EN
  logic [CNT_W-1:0] pair_cnt_q;

  // Updates on the same edge that raises both valids, so it is visible with the pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pair_cnt_q <= '0;
    end else if (pair_done) begin
      pair_cnt_q <= pair_cnt_q + 1'b1;
    end
  end

  assign pair_count = pair_cnt_q;
`endif

endmodule

// File: tb/tb_demux1x2_8bits.sv
// tb/tb_demux1x2_8bits.sv - randomized model-checked bench for two TIMEOUT settings (3 and 0).
module tb_demux1x2_8bits;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic [7:0] a_d0, a_d1, b_d0, b_d1;
  logic       a_v0, a_v1, b_v0, b_v1;
`ifdef DEMUX_PAIR_CNT_EN
  logic [7:0] a_pc, b_pc;
`endif

  always #5 clk = ~clk;

  demux1x2_8bits #(.TIMEOUT(3), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .data_out0(a_d0), .data_out1(a_d1), .valid_out0(a_v0), .valid_out1(a_v1)
`ifdef DEMUX_PAIR_CNT_EN
    , .pair_count(a_pc)
`endif
  );

  demux1x2_8bits #(.TIMEOUT(0), .CNT_W(8)) u_b (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .data_out0(b_d0), .data_out1(b_d1), .valid_out0(b_v0), .valid_out1(b_v1)
`ifdef DEMUX_PAIR_CNT_EN
    , .pair_count(b_pc)
`endif
  );

  int total = 0;
  int bad = 0;

  // Reference: bytes accumulate into an unpaired slot; two make a pair, idle time flushes one.
  int         to_m [2];
  int         pend_n [2];
  logic [7:0] pend_b [2];
  int         idle_m [2];
  int         pairs_m [2];
  logic [7:0] ed0 [2];
  logic [7:0] ed1 [2];
  logic       ev0 [2];
  logic       ev1 [2];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pend_n[k] = 0; pend_b[k] = 8'h00; idle_m[k] = 0; pairs_m[k] = 0;
      ed0[k] = 8'h00; ed1[k] = 8'h00; ev0[k] = 1'b0; ev1[k] = 1'b0;
    end
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    for (int k = 0; k < 2; k++) begin
      ev0[k] = 1'b0;
      ev1[k] = 1'b0;
      if (v) begin
        if (pend_n[k] == 1) begin
          ed1[k] = pend_b[k]; ed0[k] = d; ev0[k] = 1'b1; ev1[k] = 1'b1;
          pend_n[k] = 0; pairs_m[k] = pairs_m[k] + 1;
        end else begin
          pend_b[k] = d; pend_n[k] = 1; idle_m[k] = 0;
        end
      end else if (pend_n[k] == 1) begin
        idle_m[k] = idle_m[k] + 1;
        if (to_m[k] != 0 && idle_m[k] == to_m[k]) begin
          ed1[k] = pend_b[k]; ev1[k] = 1'b1; pend_n[k] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    check("a_data_out0", a_d0, ed0[0]);
    check("a_data_out1", a_d1, ed1[0]);
    check("a_valid_out0", a_v0, ev0[0]);
    check("a_valid_out1", a_v1, ev1[0]);
    check("b_data_out0", b_d0, ed0[1]);
    check("b_data_out1", b_d1, ed1[1]);
    check("b_valid_out0", b_v0, ev0[1]);
    check("b_valid_out1", b_v1, ev1[1]);
`ifdef DEMUX_PAIR_CNT_EN
    check("a_pair_count", a_pc, pairs_m[0] % 256);
    check("b_pair_count", b_pc, pairs_m[1] % 256);
`endif
  endtask

  // Called at a negedge; the following posedge samples the inputs.
  task automatic drive(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in = d;
    @(negedge clk);
    model_step(v, d);
    check_all();
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    #2 reset = 1'b0;
    #1 model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int pulses;
    int seen_a;
    int seen_b;
    int dens;
    logic v;
    to_m[0] = 3;
    to_m[1] = 0;
    model_reset();

    #1 reset = 1'b0;
    #3;
    check("rst_a_d0", a_d0, 0);
    check("rst_a_d1", a_d1, 0);
    check("rst_a_valids", {a_v1, a_v0}, 0);
    check("rst_b_valids", {b_v1, b_v0}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    drive(1'b1, 8'hA1);
    drive(1'b1, 8'hB2);
    check("pair1_d1", a_d1, 8'hA1);
    check("pair1_d0", a_d0, 8'hB2);
    check("pair1_valids", {a_v1, a_v0}, 2'b11);
    drive(1'b0, 8'h00);
    check("pair1_pulse_end", {a_v1, a_v0}, 2'b00);
    check("pair1_hold_d1", a_d1, 8'hA1);

    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 8'(i));
      if (a_v0 && a_v1) pulses++;
    end
    check("stream_pulses", pulses, 4);
    check("stream_last_d1", a_d1, 8'h07);
    check("stream_last_d0", a_d0, 8'h08);
`ifdef DEMUX_PAIR_CNT_EN
    check("stream_pair_count", a_pc, 5);
`endif

    drive(1'b1, 8'h5C);
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    check("flush_not_early", a_v1, 0);
    drive(1'b0, 8'h00);
    check("flush_d1", a_d1, 8'h5C);
    check("flush_valids", {a_v1, a_v0}, 2'b10);
    drive(1'b1, 8'h77);
    repeat (3) drive(1'b0, 8'h00);
    check("after_flush_lane1", a_d1, 8'h77);
    check("after_flush_valids", {a_v1, a_v0}, 2'b10);

    drive(1'b1, 8'h10);
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    drive(1'b1, 8'h20);
    check("pair_wins_d1", a_d1, 8'h10);
    check("pair_wins_d0", a_d0, 8'h20);
    check("pair_wins_valids", {a_v1, a_v0}, 2'b11);
    drive(1'b0, 8'h00);

    drive(1'b1, 8'hEE);
    valid_in = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("midrst_a_d1", a_d1, 0);
    check("midrst_a_d0", a_d0, 0);
    check("midrst_b_d1", b_d1, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 8'h33);
    drive(1'b1, 8'h44);
    check("post_rst_d1", a_d1, 8'h33);
    check("post_rst_d0", a_d0, 8'h44);
    check("post_rst_valids", {a_v1, a_v0}, 2'b11);

    dens = 2;
    for (int c = 0; c < 1500; c++) begin
      if (c % 64 == 0) dens = int'($urandom_range(1, 4));
      v = ($urandom_range(0, 3) < dens);
      drive(v, 8'($urandom));
    end

`ifdef DEMUX_PAIR_CNT_EN
    repeat (4) drive(1'b0, 8'h00);
    for (int n = 0; n < 256 && (pairs_m[0] % 256) != 0; n++) begin
      drive(1'b1, 8'($urandom));
      drive(1'b1, 8'($urandom));
    end
    check("pair_count_wrap", a_pc, 0);
`endif

    do_reset();
    drive(1'b1, 8'h99);
    seen_a = 0;
    seen_b = 0;
    repeat (20) begin
      drive(1'b0, 8'h00);
      if (a_v1) seen_a++;
      if (b_v0 || b_v1) seen_b++;
    end
    check("to3_one_flush", seen_a, 1);
    check("to0_no_emit", seen_b, 0);
    drive(1'b1, 8'hAB);
    check("to0_held_d1", b_d1, 8'h99);
    check("to0_held_d0", b_d0, 8'hAB);
    check("to0_held_valids", {b_v1, b_v0}, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
